// File: rtl/byte_serial_adder_pkg.sv
// Shared types and constants for the byte-serial adder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   BYTE_W         - width of one adder lane
//   NBYTES_DEFAULT - default operand width in bytes
//   state_t        - control FSM states (IDLE, RUN, DONE)
//   op_bits()      - operand width in bits for a given byte count
package byte_serial_adder_pkg;

    localparam int BYTE_W         = 8;
    localparam int NBYTES_DEFAULT = 4;

    // IDLE: waiting for an operand set.
    // RUN : one byte lane resolved per cycle, least significant first.
    // DONE: result presented until the consumer takes it.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int op_bits(input int nbytes);
        return nbytes * BYTE_W;
    endfunction

endpackage

// File: rtl/byte_serial_adder_adder8.sv
// Plain 8-bit ripple adder with carry in and carry out.
// Latency: combinational, zero cycles.
// Backpressure: none; output follows inputs.
//
// Ports:
//   a, b - 8-bit addends
//   cin  - carry in
//   sum  - low 8 bits of a + b + cin
//   cout - carry out of bit 7
module adder8 (
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic       cin,
    output logic [7:0] sum,
    output logic       cout
);

    assign {cout, sum} = {1'b0, a} + {1'b0, b} + {8'd0, cin};

endmodule

// File: rtl/byte_serial_adder.sv
// Byte-serial unsigned adder: one 8-bit adder reused over NBYTES cycles.
// Latency: result valid NBYTES cycles after acceptance; new accept every NBYTES+2 cycles min.
// Backpressure: in_ready only in IDLE; result held in DONE until out_ready.
//
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   in_valid / in_ready - operand handshake for a, b, cin
//   a, b, cin           - unsigned operands and carry in, sampled at acceptance only
//   out_valid/out_ready - result handshake
//   sum, cout           - (a + b + cin) mod 2^(8*NBYTES) and final carry out
module byte_serial_adder
    import byte_serial_adder_pkg::*;
#(
    parameter int NBYTES = NBYTES_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [BYTE_W*NBYTES-1:0] a,
    input  logic [BYTE_W*NBYTES-1:0] b,
    input  logic                     cin,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [BYTE_W*NBYTES-1:0] sum,
    output logic                     cout
);

    localparam int            OP_W     = op_bits(NBYTES);
    localparam int            IDX_W    = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    state_t state_q;
    state_t state_d;

    logic accept;    // operand set taken this cycle
    logic step;      // one byte lane resolved this cycle
    logic last;      // the lane being resolved is the most significant one

    logic [IDX_W-1:0] idx_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        step      = 1'b0;
        last      = 1'b0;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (idx_q == IDX_LAST) begin
                    last    = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    logic [OP_W-1:0] a_q;
    logic [OP_W-1:0] b_q;
    logic            carry_q;
    logic [OP_W-1:0] sum_q;
    logic            cout_q;

    logic [BYTE_W-1:0] lane_a;
    logic [BYTE_W-1:0] lane_b;
    logic [BYTE_W-1:0] lane_sum;
    logic              lane_cout;

    // Current lane of the captured operands; the carry register chains lanes.
    assign lane_a = a_q[idx_q*BYTE_W +: BYTE_W];
    assign lane_b = b_q[idx_q*BYTE_W +: BYTE_W];

    adder8 u_adder8 (
        .a    (lane_a),
        .b    (lane_b),
        .cin  (carry_q),
        .sum  (lane_sum),
        .cout (lane_cout)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            if (accept) begin
                a_q     <= a;
                b_q     <= b;
                carry_q <= cin;
                idx_q   <= '0;
            end
            if (step) begin
                sum_q[idx_q*BYTE_W +: BYTE_W] <= lane_sum;
                carry_q                       <= lane_cout;
                idx_q                         <= idx_q + IDX_W'(1);
                // Only the top lane's carry is architecturally visible;
                // cout keeps the previous result until then.
                if (last) begin
                    cout_q <= lane_cout;
                end
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: doc/byte_serial_adder.md
BYTE_SERIAL_ADDER -- requirements
Module: byte_serial_adder

Interface
- REQ-001: Parameter NBYTES SHALL have default 4 and set the operand width in bytes (legal range 2..16).
- REQ-002: Port clk SHALL be an input, 1 bit: the single clock; all state updates on its rising edge.
- REQ-003: Port rst_n SHALL be an input, 1 bit: reset, synchronous and active-low.
- REQ-004: Port in_valid SHALL be an input, 1 bit: the operand set on a, b and cin is valid.
- REQ-005: Port in_ready SHALL be an output, 1 bit: the block can accept an operand set.
- REQ-006: Port a SHALL be an input, 8*NBYTES bits: first operand, unsigned.
- REQ-007: Port b SHALL be an input, 8*NBYTES bits: second operand, unsigned.
- REQ-008: Port cin SHALL be an input, 1 bit: carry-in to byte 0.
- REQ-009: Port out_valid SHALL be an output, 1 bit: sum and cout hold a completed result.
- REQ-010: Port out_ready SHALL be an input, 1 bit: the consumer accepts the result.
- REQ-011: Port sum SHALL be an output, 8*NBYTES bits: the result, equal to (a + b + cin) mod 2^(8*NBYTES).
- REQ-012: Port cout SHALL be an output, 1 bit: carry-out of the most significant byte.

Function
- REQ-013: The block SHALL have three states: IDLE, RUN and DONE.
- REQ-014: In IDLE, in_ready SHALL be 1; in RUN and DONE it SHALL be 0.
- REQ-015: On a clock edge with in_valid && in_ready, the block SHALL register a, b and cin, clear the byte index to 0, and enter RUN.
- REQ-016: Operand inputs SHALL be sampled only at acceptance; later changes to a, b or cin SHALL NOT affect the result.
- REQ-017: In RUN, each cycle SHALL feed byte[idx] of the registered a and b, plus the carry register, into one 8-bit adder.
- REQ-018: Within that same RUN cycle, the adder sum SHALL be written to sum byte[idx], its carry-out SHALL be registered as the next carry, and idx SHALL increment.
- REQ-019: When idx == NBYTES-1, the RUN cycle SHALL write the last byte, load cout from the adder carry-out, and enter DONE.
- REQ-020: Latency: with acceptance at edge k, out_valid SHALL be 1 after edge k+NBYTES.
- REQ-021: In DONE, out_valid SHALL be 1, and sum and cout SHALL be held stable while out_ready is 0, for any duration.
- REQ-022: On an edge in DONE with out_ready = 1, the block SHALL return to IDLE with out_valid = 0.
- REQ-023: Minimum spacing between acceptances SHALL be NBYTES+2 cycles.
- REQ-024: in_valid asserted in RUN or DONE SHALL be ignored, with no state change and no lost result.
- REQ-025: After a result is taken, sum and cout SHALL retain their values in IDLE until overwritten by the next RUN.
- REQ-026: out_ready while out_valid = 0 SHALL have no effect.
- REQ-027: Wrap-around: an all-ones operand plus cin = 1 SHALL give sum = 0 and cout = 1.

Reset
- REQ-028: With rst_n = 0 at a clock edge, the state SHALL become IDLE, with idx = 0, the carry register = 0, sum = 0, cout = 0, out_valid = 0 and in_ready = 1 from the next cycle.
- REQ-029: Reset asserted in RUN or DONE SHALL discard the operation in progress without emitting any partial result.
- REQ-030: The block SHALL NOT use asynchronous reset logic.

Structure
- REQ-031: Package byte_serial_adder_pkg SHALL hold the state enum type (IDLE, RUN, DONE), the BYTE_W = 8 constant and the default NBYTES.
- REQ-032: The block SHALL instantiate exactly one existing adder8 sub-module, unchanged (ports a, b, cin, sum, cout); it SHALL contain no other adder logic.
- REQ-033: The byte index SHALL be $clog2(NBYTES) bits wide.

Verification (NBYTES = 4)
- REQ-034: a = 4, b = 17, cin = 0 accepted -> out_valid after exactly 4 edges, with sum = 21 and cout = 0.
- REQ-035: a = 32'h000000FF, b = 1, cin = 0 -> sum = 32'h00000100 and cout = 0 (carry crosses a byte boundary).
- REQ-036: a = 32'hFFFFFFFF, b = 0, cin = 1 -> sum = 0 and cout = 1; also a = 32'hC8000000, b = 32'h37000000, cin = 0 -> sum = 32'hFF000000 and cout = 0.
- REQ-037: out_ready held 0 for 5 cycles in DONE, with a new in_valid and changed a/b applied -> sum, cout and out_valid stay stable, in_ready stays 0, and the second operand set is not accepted.
- REQ-038: rst_n pulsed low for 1 cycle at RUN idx = 2 -> next cycle shows IDLE, sum = 0, out_valid = 0; a following add of 7 + 20 gives 27.
- REQ-039: Back-to-back operand sets with out_ready tied to 1 -> acceptances spaced NBYTES+2 cycles apart and every result correct against a reference model, including 200 + 55 + cin 1 per byte lane.
